// File: rtl/rll_ctrl_pkg.sv
// Shared types and defaults for RLL key-loading controllers.
package rll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    GAP    = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } state_e;

  localparam int DEF_KEY_W   = 16;
  localparam int DEF_WORD_W  = 4;
  localparam int DEF_OUT_W   = 32;
  localparam int DEF_TIMEOUT = 15;

  // Address width that stays legal for a single-word key store.
  function automatic int addr_width(input int num_words);
    if (num_words > 1) begin
      return $clog2(num_words);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rll_timeout_ctr.sv
// Loadable down counter; expire_o flags the decrement that would run it out.
module rll_timeout_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over load, load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = dec_i && (cnt_q == W'(1));

endmodule

// File: rtl/rll_key_loader.sv
// Fetches an RLL unlock key word by word, publishes it atomically and
// gates the locked circuit's outputs until a complete key is present.
module rll_key_loader
  import rll_ctrl_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    key_clear,
  output logic                                    mem_req,
  output logic [addr_width(KEY_W/WORD_W)-1:0]     mem_addr,
  input  logic                                    mem_ack,
  input  logic [WORD_W-1:0]                       mem_data,
  output logic [KEY_W-1:0]                        key_out,
  output logic                                    key_valid,
  output logic                                    busy,
  output logic                                    err,
  input  logic [OUT_W-1:0]                        ckt_out_in,
  output logic [OUT_W-1:0]                        ckt_out
);

  localparam int NUM_WORDS = KEY_W / WORD_W;
  localparam int AW        = addr_width(NUM_WORDS);
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d;
  logic [KEY_W-1:0]  key_out_q, key_out_d;
  logic              key_valid_q, key_valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              tmr_load_s;
  logic              tmr_dec_s;
  logic              tmr_expire_s;

  assign tmr_dec_s = (state_q == FETCH) && !mem_ack && !key_clear;

  rll_timeout_ctr #(
    .W (TW)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (key_clear),
    .load_i     (tmr_load_s),
    .load_val_i (TW'(TIMEOUT)),
    .dec_i      (tmr_dec_s),
    .expire_o   (tmr_expire_s)
  );

  // Next-state and registered-output computation; key_clear overrides all.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    tmr_load_s  = 1'b0;
    if (key_clear) begin
      state_d     = IDLE;
      mem_addr_d  = '0;
      shadow_d    = '0;
      key_out_d   = '0;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = FETCH;
            mem_addr_d  = '0;
            shadow_d    = '0;
            key_valid_d = 1'b0;
            tmr_load_s  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          // An ack in the expiry cycle still counts as a successful fetch.
          if (mem_ack) begin
            shadow_d[int'(mem_addr_q)*WORD_W +: WORD_W] = mem_data;
            if (mem_addr_q == LAST_ADDR) begin
              state_d = COMMIT;
            end else begin
              state_d    = GAP;
              mem_addr_d = mem_addr_q + AW'(1);
            end
          end else if (tmr_expire_s) begin
            state_d     = ERROR;
            err_d       = 1'b1;
            key_out_d   = '0;
            key_valid_d = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
        GAP: begin
          state_d    = FETCH;
          tmr_load_s = 1'b1;
        end
        COMMIT: begin
          state_d     = IDLE;
          key_out_d   = shadow_q;
          key_valid_d = 1'b1;
          mem_addr_d  = '0;
        end
        ERROR: begin
          if (start) begin
            state_d    = FETCH;
            mem_addr_d = '0;
            shadow_d   = '0;
            err_d      = 1'b0;
            tmr_load_s = 1'b1;
          end else begin
            state_d = ERROR;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d    = (state_d == FETCH) || (state_d == GAP) || (state_d == COMMIT);
    mem_req_d = (state_d == FETCH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      shadow_q    <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign ckt_out   = key_valid_q ? ckt_out_in : '0;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed-plus-random bench for rll_key_loader with a word-assembly key model.
module tb_rll_key_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        key_clear;
  logic        mem_req;
  logic [1:0]  mem_addr;
  logic        mem_ack;
  logic [3:0]  mem_data;
  logic [15:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [31:0] ckt_out_in;
  logic [31:0] ckt_out;

  int checks;
  int errors;
  logic [15:0] model_key;
  logic [3:0]  words [4];
  int          dly   [4];

  rll_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_clear  (key_clear),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .ckt_out_in (ckt_out_in),
    .ckt_out    (ckt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(key_valid), 64'd0);
    chk({tag, "_key"}, 64'(key_out), 64'd0);
    chk({tag, "_ckt"}, 64'(ckt_out), 64'd0);
  endtask

  // Full load driven by words[]/dly[]; the key store acks after dly[i] wait cycles.
  task automatic run_load(input bit clr_last);
    int cyc;
    int sum;
    logic [15:0] exp_key;
    sum = 0;
    exp_key = 16'd0;
    for (int i = 0; i < 4; i++) begin
      sum += dly[i];
      exp_key = exp_key | (16'(words[i]) << (4 * i));
    end
    ckt_out_in = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("valid_drop", 64'(key_valid), 64'd0);
    chk("err_clear", 64'(err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      int waitc;
      waitc = 0;
      while (waitc < dly[i] && waitc < 16) begin
        chk("req_wait", 64'(mem_req), 64'd1);
        chk("addr_hold", 64'(mem_addr), 64'(i));
        chk("gated_load", 64'(ckt_out), 64'd0);
        mem_data = 4'($urandom);
        tick();
        cyc++;
        waitc++;
      end
      chk("req_fetch", 64'(mem_req), 64'd1);
      chk("addr_fetch", 64'(mem_addr), 64'(i));
      chk("no_partial", 64'(key_out), 64'(model_key));
      mem_ack = 1'b1;
      mem_data = words[i];
      if (i == 3 && clr_last) begin
        key_clear = 1'b1;
      end
      tick();
      cyc++;
      mem_ack = 1'b0;
      key_clear = 1'b0;
      if (i == 3 && clr_last) begin
        model_key = 16'd0;
        chk_idle_outputs("clr_last");
        tick();
        chk_idle_outputs("clr_nocommit");
        return;
      end
      if (i < 3) begin
        chk("gap_req", 64'(mem_req), 64'd0);
        chk("gap_busy", 64'(busy), 64'd1);
        mem_ack = 1'b1;
        mem_data = 4'($urandom);
        tick();
        cyc++;
        mem_ack = 1'b0;
      end
    end
    chk("commit_busy", 64'(busy), 64'd1);
    chk("commit_valid", 64'(key_valid), 64'd0);
    chk("commit_key", 64'(key_out), 64'(model_key));
    tick();
    cyc++;
    model_key = exp_key;
    chk("key_out", 64'(key_out), 64'(model_key));
    chk("key_valid", 64'(key_valid), 64'd1);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("latency", 64'(cyc), 64'(2 * 4 + 1 + sum));
    chk("ckt_pass", 64'(ckt_out), 64'(ckt_out_in));
    ckt_out_in = $urandom;
    #1;
    chk("ckt_comb", 64'(ckt_out), 64'(ckt_out_in));
  endtask

  task automatic set_words(input logic [15:0] k);
    for (int i = 0; i < 4; i++) begin
      words[i] = 4'(k >> (4 * i));
      dly[i] = 0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_key = 16'd0;
    rst_n = 1'b0;
    start = 1'b0;
    key_clear = 1'b0;
    mem_ack = 1'b0;
    mem_data = 4'd0;
    ckt_out_in = 32'hDEAD_BEEF;
    #22;
    chk_idle_outputs("reset");
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-wait load of 0x3C5A.
    set_words(16'h3C5A);
    run_load(1'b0);
    chk("key_3c5a", 64'(key_out), 64'h3C5A);

    // Word 2 acked after 3 wait cycles.
    set_words(16'h3C5A);
    dly[2] = 3;
    run_load(1'b0);

    // Ack on the 15th wait cycle of word 1 must not time out.
    for (int i = 0; i < 4; i++) begin
      words[i] = 4'($urandom);
      dly[i] = 0;
    end
    dly[1] = 14;
    run_load(1'b0);
    chk("boundary_err", 64'(err), 64'd0);

    // Random words and wait times.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        words[i] = 4'($urandom);
        dly[i] = int'($urandom_range(0, 14));
      end
      run_load(1'b0);
    end

    // Timeout on word 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_data = 4'h7;
    tick();
    mem_ack = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_err", 64'(err), 64'd0);
      chk("to_wait_req", 64'(mem_req), 64'd1);
      tick();
    end
    model_key = 16'd0;
    chk("to_err", 64'(err), 64'd1);
    chk_idle_outputs("to");
    tick();
    chk("to_sticky", 64'(err), 64'd1);
    set_words(16'hB16E);
    run_load(1'b0);
    chk("to_recover_err", 64'(err), 64'd0);

    // key_clear racing the last ack, then start+key_clear together.
    set_words(16'h1234);
    run_load(1'b0);
    chk("key_1234", 64'(key_out), 64'h1234);
    set_words(16'h9E71);
    run_load(1'b1);
    start = 1'b1;
    key_clear = 1'b1;
    tick();
    start = 1'b0;
    key_clear = 1'b0;
    chk_idle_outputs("start_clr");
    tick();
    chk_idle_outputs("start_clr2");

    // Asynchronous reset in the middle of a fetch.
    set_words(16'h5AA5);
    run_load(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_key = 16'd0;
    chk_idle_outputs("async_rst");
    chk("async_rst_addr", 64'(mem_addr), 64'd0);
    chk("async_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("post_rst");
    tick();
    chk_idle_outputs("post_rst2");
    for (int i = 0; i < 4; i++) begin
      words[i] = 4'($urandom);
      dly[i] = int'($urandom_range(0, 2));
    end
    run_load(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
